// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and types for the operand fetch stage.
package rv32i_pkg;

   localparam int XLEN_DEFAULT = 32;
   localparam int REG_ADDR_W   = 5;
   localparam int NUM_REGS     = 32;

   typedef enum logic [1:0] {
      SEL_ZERO,
      SEL_BYPASS,
      SEL_RF
   } opsel_t;

   typedef enum logic {
      OUT_EMPTY,
      OUT_FULL
   } out_state_t;

   // x0 is hardwired zero, so it outranks a same-cycle writeback to it.
   function automatic opsel_t select_operand(input logic [REG_ADDR_W-1:0] addr,
                                             input logic                  wb_valid,
                                             input logic [REG_ADDR_W-1:0] wb_rd);
      opsel_t sel;
      if (addr == '0)
         sel = SEL_ZERO;
      else if (wb_valid && (wb_rd == addr))
         sel = SEL_BYPASS;
      else
         sel = SEL_RF;
      return sel;
   endfunction

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Register busy scoreboard: one pending-write bit per architectural register.
module scoreboard
   import rv32i_pkg::*;
(
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  set_en,
   input  logic [REG_ADDR_W-1:0] set_idx,
   input  logic                  wb_clr_en,
   input  logic [REG_ADDR_W-1:0] wb_clr_idx,
   input  logic                  flush_clr_en,
   input  logic [REG_ADDR_W-1:0] flush_clr_idx,
   input  logic [REG_ADDR_W-1:0] rs1_idx,
   input  logic [REG_ADDR_W-1:0] rs2_idx,
   input  logic [REG_ADDR_W-1:0] rd_idx,
   output logic                  rs1_busy,
   output logic                  rs2_busy,
   output logic                  rd_busy
);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;

   // Clears are applied first so a same-cycle set of the same index wins.
   always_comb begin
      busy_d = busy_q;
      if (wb_clr_en)
         busy_d[wb_clr_idx] = 1'b0;
      if (flush_clr_en)
         busy_d[flush_clr_idx] = 1'b0;
      if (set_en)
         busy_d[set_idx] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rstn)
         busy_q <= '0;
      else
         busy_q <= busy_d;
   end

   assign rs1_busy = busy_q[rs1_idx];
   assign rs2_busy = busy_q[rs2_idx];
   assign rd_busy  = busy_q[rd_idx];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: hazard check, register read with writeback bypass,
// and a single-entry output register toward execute.
module operand_fetch
   import rv32i_pkg::*;
#(
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int CTRLW = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  id_valid,
   output logic                  id_ready,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_use_rs1,
   input  logic                  id_use_rs2,
   input  logic                  id_wr_rd,
   input  logic [CTRLW-1:0]      id_ctrl,
   output logic [REG_ADDR_W-1:0] rf_rs1_raddr,
   output logic [REG_ADDR_W-1:0] rf_rs2_raddr,
   input  logic [XLEN-1:0]       rf_rs1_rdata,
   input  logic [XLEN-1:0]       rf_rs2_rdata,
   input  logic                  wb_valid,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic [XLEN-1:0]       wb_data,
   input  logic                  flush,
   output logic                  ex_valid,
   input  logic                  ex_ready,
   output logic [XLEN-1:0]       ex_rs1_data,
   output logic [XLEN-1:0]       ex_rs2_data,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  ex_wr_rd,
   output logic [CTRLW-1:0]      ex_ctrl,
   output logic [15:0]           stall_cnt
);

   out_state_t state_q;
   out_state_t state_d;

   logic rs1_busy, rs2_busy, rd_busy;
   logic rs1_haz, rs2_haz, waw_haz, hazard;
   logic issue, set_en, wb_clr_en, flush_clr_en;
   logic [XLEN-1:0] rs1_val, rs2_val;

   assign rf_rs1_raddr = id_rs1;
   assign rf_rs2_raddr = id_rs2;

   assign rs1_haz = id_use_rs1 && rs1_busy && !(wb_valid && (wb_rd == id_rs1));
   assign rs2_haz = id_use_rs2 && rs2_busy && !(wb_valid && (wb_rd == id_rs2));
   assign waw_haz = id_wr_rd && (id_rd != '0) && rd_busy
                    && !(wb_valid && (wb_rd == id_rd));
   assign hazard  = rs1_haz || rs2_haz || waw_haz;

   assign ex_valid = (state_q == OUT_FULL);
   assign id_ready = rstn && !flush && !hazard && (!ex_valid || ex_ready);
   assign issue    = id_valid && id_ready;

   // A flushed entry that never reached execute will never write back.
   assign set_en       = issue && id_wr_rd && (id_rd != '0);
   assign wb_clr_en    = wb_valid && (wb_rd != '0);
   assign flush_clr_en = flush && ex_valid && !ex_ready && ex_wr_rd && (ex_rd != '0);

   scoreboard u_scoreboard (
      .clk           (clk),
      .rstn          (rstn),
      .set_en        (set_en),
      .set_idx       (id_rd),
      .wb_clr_en     (wb_clr_en),
      .wb_clr_idx    (wb_rd),
      .flush_clr_en  (flush_clr_en),
      .flush_clr_idx (ex_rd),
      .rs1_idx       (id_rs1),
      .rs2_idx       (id_rs2),
      .rd_idx        (id_rd),
      .rs1_busy      (rs1_busy),
      .rs2_busy      (rs2_busy),
      .rd_busy       (rd_busy)
   );

   always_comb begin
      rs1_val = '0;
      rs2_val = '0;
      if (id_use_rs1) begin
         case (select_operand(id_rs1, wb_valid, wb_rd))
            SEL_BYPASS: rs1_val = wb_data;
            SEL_RF:     rs1_val = rf_rs1_rdata;
            default:    rs1_val = '0;
         endcase
      end
      if (id_use_rs2) begin
         case (select_operand(id_rs2, wb_valid, wb_rd))
            SEL_BYPASS: rs2_val = wb_data;
            SEL_RF:     rs2_val = rf_rs2_rdata;
            default:    rs2_val = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn)
         state_q <= OUT_EMPTY;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         OUT_EMPTY: if (issue) state_d = OUT_FULL;
         OUT_FULL:  if (ex_ready && !issue) state_d = OUT_EMPTY;
         default:   state_d = OUT_EMPTY;
      endcase
      if (flush)
         state_d = OUT_EMPTY;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
         ex_rd       <= '0;
         ex_wr_rd    <= 1'b0;
         ex_ctrl     <= '0;
      end else if (issue) begin
         ex_rs1_data <= rs1_val;
         ex_rs2_data <= rs2_val;
         ex_rd       <= id_rd;
         ex_wr_rd    <= id_wr_rd;
         ex_ctrl     <= id_ctrl;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn)
         stall_cnt <= '0;
      else if (id_valid && hazard && (stall_cnt != 16'hFFFF))
         stall_cnt <= stall_cnt + 16'd1;
   end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: table of single-issue vectors plus
// hand-written hazard, backpressure, flush, saturation and reset sequences.
module tb_operand_fetch;

   logic        clk = 1'b0;
   logic        rstn;
   logic        id_valid, id_ready;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_use_rs1, id_use_rs2, id_wr_rd;
   logic [15:0] id_ctrl;
   logic [4:0]  rf_rs1_raddr, rf_rs2_raddr;
   logic [31:0] rf_rs1_rdata, rf_rs2_rdata;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        flush;
   logic        ex_valid, ex_ready;
   logic [31:0] ex_rs1_data, ex_rs2_data;
   logic [4:0]  ex_rd;
   logic        ex_wr_rd;
   logic [15:0] ex_ctrl;
   logic [15:0] stall_cnt;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] exp_stall = 16'd0;

   always #5 clk = ~clk;

   operand_fetch #(.XLEN(32), .CTRLW(16)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .id_valid     (id_valid),
      .id_ready     (id_ready),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_rd        (id_rd),
      .id_use_rs1   (id_use_rs1),
      .id_use_rs2   (id_use_rs2),
      .id_wr_rd     (id_wr_rd),
      .id_ctrl      (id_ctrl),
      .rf_rs1_raddr (rf_rs1_raddr),
      .rf_rs2_raddr (rf_rs2_raddr),
      .rf_rs1_rdata (rf_rs1_rdata),
      .rf_rs2_rdata (rf_rs2_rdata),
      .wb_valid     (wb_valid),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .flush        (flush),
      .ex_valid     (ex_valid),
      .ex_ready     (ex_ready),
      .ex_rs1_data  (ex_rs1_data),
      .ex_rs2_data  (ex_rs2_data),
      .ex_rd        (ex_rd),
      .ex_wr_rd     (ex_wr_rd),
      .ex_ctrl      (ex_ctrl),
      .stall_cnt    (stall_cnt)
   );

   typedef struct {
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        u1;
      logic        u2;
      logic [15:0] ctrl;
      logic [31:0] rf1;
      logic [31:0] rf2;
      logic        wbv;
      logic [4:0]  wbrd;
      logic [31:0] wbd;
      logic [31:0] exp1;
      logic [31:0] exp2;
   } vec_t;

   vec_t vecs[6];

   task automatic check_output(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic v, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic u1, input logic u2, input logic wr,
                                 input logic [15:0] ctrl);
      id_valid   = v;
      id_rs1     = rs1;
      id_rs2     = rs2;
      id_rd      = rd;
      id_use_rs1 = u1;
      id_use_rs2 = u2;
      id_wr_rd   = wr;
      id_ctrl    = ctrl;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      apply_stimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 16'h0);
      wb_valid = 1'b0;
      wb_rd    = 5'd0;
      wb_data  = 32'h0;
      flush    = 1'b0;
   endtask

   initial begin
      vecs[0] = '{5'd1, 5'd2,  1'b1, 1'b1, 16'h0001, 32'h11110001, 32'h22220002,
                  1'b0, 5'd0,  32'h0,        32'h11110001, 32'h22220002};
      vecs[1] = '{5'd0, 5'd3,  1'b1, 1'b1, 16'h0002, 32'hFFFFFFFF, 32'h33333333,
                  1'b0, 5'd0,  32'h0,        32'h00000000, 32'h33333333};
      vecs[2] = '{5'd4, 5'd5,  1'b1, 1'b1, 16'h0003, 32'h44444444, 32'h55555555,
                  1'b1, 5'd4,  32'hCAFEF00D, 32'hCAFEF00D, 32'h55555555};
      vecs[3] = '{5'd6, 5'd6,  1'b0, 1'b1, 16'h0004, 32'h66666666, 32'h66666666,
                  1'b1, 5'd6,  32'h0BADC0DE, 32'h00000000, 32'h0BADC0DE};
      vecs[4] = '{5'd0, 5'd8,  1'b1, 1'b0, 16'h0005, 32'h77777777, 32'h88888888,
                  1'b1, 5'd0,  32'h00001234, 32'h00000000, 32'h00000000};
      vecs[5] = '{5'd9, 5'd10, 1'b1, 1'b1, 16'h0006, 32'h99999999, 32'hAAAAAAAA,
                  1'b1, 5'd10, 32'h12345678, 32'h99999999, 32'h12345678};

      idle();
      rf_rs1_rdata = 32'h0;
      rf_rs2_rdata = 32'h0;
      ex_ready     = 1'b1;
      rstn         = 1'b0;
      step();
      check_output("reset_id_ready", {31'd0, id_ready}, 32'd0);
      step();
      check_output("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
      check_output("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
      check_output("reset_ex_rs1", ex_rs1_data, 32'd0);
      check_output("reset_ex_ctrl", {16'd0, ex_ctrl}, 32'd0);
      rstn = 1'b1;

      // Table: one issue per cycle, no destination writes, execute always ready.
      for (int i = 0; i < 6; i++) begin
         apply_stimulus(1'b1, vecs[i].rs1, vecs[i].rs2, 5'(i + 1),
                        vecs[i].u1, vecs[i].u2, 1'b0, vecs[i].ctrl);
         rf_rs1_rdata = vecs[i].rf1;
         rf_rs2_rdata = vecs[i].rf2;
         wb_valid     = vecs[i].wbv;
         wb_rd        = vecs[i].wbrd;
         wb_data      = vecs[i].wbd;
         #1;
         check_output($sformatf("vec%0d_id_ready", i), {31'd0, id_ready}, 32'd1);
         check_output($sformatf("vec%0d_raddr1", i), {27'd0, rf_rs1_raddr}, {27'd0, vecs[i].rs1});
         step();
         check_output($sformatf("vec%0d_ex_valid", i), {31'd0, ex_valid}, 32'd1);
         check_output($sformatf("vec%0d_ex_rs1", i), ex_rs1_data, vecs[i].exp1);
         check_output($sformatf("vec%0d_ex_rs2", i), ex_rs2_data, vecs[i].exp2);
         check_output($sformatf("vec%0d_ex_ctrl", i), {16'd0, ex_ctrl}, {16'd0, vecs[i].ctrl});
         check_output($sformatf("vec%0d_ex_rd", i), {27'd0, ex_rd}, i + 1);
      end
      idle();

      // Back-to-back RAW on x5, released by a bypassed writeback.
      apply_stimulus(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 16'h0010);
      step();
      apply_stimulus(1'b1, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 16'h0011);
      rf_rs1_rdata = 32'h11111111;
      for (int k = 0; k < 2; k++) begin
         #1;
         check_output("raw_stall_id_ready", {31'd0, id_ready}, 32'd0);
         step();
         exp_stall++;
      end
      check_output("raw_stall_cnt", {16'd0, stall_cnt}, {16'd0, exp_stall});
      wb_valid = 1'b1;
      wb_rd    = 5'd5;
      wb_data  = 32'hDEADBEEF;
      #1;
      check_output("raw_release_id_ready", {31'd0, id_ready}, 32'd1);
      step();
      wb_valid = 1'b0;
      check_output("raw_ex_rs1", ex_rs1_data, 32'hDEADBEEF);
      check_output("raw_ex_ctrl", {16'd0, ex_ctrl}, 32'h0011);
      check_output("raw_stall_cnt_after", {16'd0, stall_cnt}, {16'd0, exp_stall});

      // Writes to x0 never mark busy and reads of x0 ignore a bypass.
      apply_stimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 16'h0020);
      step();
      apply_stimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 16'h0021);
      rf_rs1_rdata = 32'h55555555;
      wb_valid = 1'b1;
      wb_rd    = 5'd0;
      wb_data  = 32'h00001234;
      #1;
      check_output("x0_id_ready", {31'd0, id_ready}, 32'd1);
      step();
      idle();
      check_output("x0_ex_rs1", ex_rs1_data, 32'd0);
      check_output("x0_stall_cnt", {16'd0, stall_cnt}, {16'd0, exp_stall});

      // Backpressure: hold a full entry for three cycles.
      step();
      ex_ready = 1'b0;
      apply_stimulus(1'b1, 5'd1, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 16'hAAAA);
      rf_rs1_rdata = 32'hA1A1A1A1;
      step();
      check_output("bp_first_ex_ctrl", {16'd0, ex_ctrl}, 32'hAAAA);
      apply_stimulus(1'b1, 5'd2, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 16'hBBBB);
      rf_rs1_rdata = 32'hB2B2B2B2;
      for (int k = 0; k < 3; k++) begin
         #1;
         check_output("bp_id_ready", {31'd0, id_ready}, 32'd0);
         step();
         check_output("bp_hold_valid", {31'd0, ex_valid}, 32'd1);
         check_output("bp_hold_ctrl", {16'd0, ex_ctrl}, 32'hAAAA);
         check_output("bp_hold_rs1", ex_rs1_data, 32'hA1A1A1A1);
         check_output("bp_hold_rd", {27'd0, ex_rd}, 32'd8);
      end
      ex_ready = 1'b1;
      #1;
      check_output("bp_release_id_ready", {31'd0, id_ready}, 32'd1);
      step();
      check_output("bp_next_ctrl", {16'd0, ex_ctrl}, 32'hBBBB);
      check_output("bp_next_rs1", ex_rs1_data, 32'hB2B2B2B2);
      check_output("bp_stall_cnt", {16'd0, stall_cnt}, {16'd0, exp_stall});
      idle();
      step();

      // Flush of an un-accepted entry writing x7 must free x7.
      ex_ready = 1'b0;
      apply_stimulus(1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 16'h0070);
      step();
      check_output("flush_pre_ex_rd", {27'd0, ex_rd}, 32'd7);
      check_output("flush_pre_valid", {31'd0, ex_valid}, 32'd1);
      idle();
      flush = 1'b1;
      apply_stimulus(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 16'h0071);
      #1;
      check_output("flush_blocks_issue", {31'd0, id_ready}, 32'd0);
      step();
      flush = 1'b0;
      check_output("flush_ex_valid", {31'd0, ex_valid}, 32'd0);
      apply_stimulus(1'b1, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 16'h0072);
      rf_rs1_rdata = 32'h77770007;
      #1;
      check_output("flush_reader_ready", {31'd0, id_ready}, 32'd1);
      step();
      check_output("flush_reader_valid", {31'd0, ex_valid}, 32'd1);
      check_output("flush_reader_rs1", ex_rs1_data, 32'h77770007);
      ex_ready = 1'b1;
      idle();
      step();

      // WAW on x3, then saturate the stall counter.
      apply_stimulus(1'b1, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 16'h0030);
      step();
      apply_stimulus(1'b1, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 16'h0031);
      for (int k = 0; k < 3; k++) begin
         #1;
         check_output("waw_id_ready", {31'd0, id_ready}, 32'd0);
         step();
         exp_stall++;
      end
      check_output("waw_stall_cnt", {16'd0, stall_cnt}, {16'd0, exp_stall});
      wb_valid = 1'b1;
      wb_rd    = 5'd3;
      wb_data  = 32'h33333333;
      #1;
      check_output("waw_release_ready", {31'd0, id_ready}, 32'd1);
      step();
      wb_valid = 1'b0;
      check_output("waw_ex_ctrl", {16'd0, ex_ctrl}, 32'h0031);
      check_output("waw_ex_wr_rd", {31'd0, ex_wr_rd}, 32'd1);
      #1;
      check_output("waw_set_wins", {31'd0, id_ready}, 32'd0);
      for (int k = 0; k < 65540; k++) begin
         step();
         if (exp_stall != 16'hFFFF)
            exp_stall++;
      end
      check_output("sat_stall_cnt", {16'd0, stall_cnt}, {16'd0, exp_stall});
      step();
      check_output("sat_hold", {16'd0, stall_cnt}, 32'h0000FFFF);
      idle();
      step();

      // Reset while full with x9 busy.
      ex_ready = 1'b0;
      apply_stimulus(1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 16'h0090);
      step();
      check_output("rst_pre_valid", {31'd0, ex_valid}, 32'd1);
      apply_stimulus(1'b1, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 16'h0091);
      rf_rs1_rdata = 32'h99990009;
      rstn = 1'b0;
      #1;
      check_output("rst_id_ready_low", {31'd0, id_ready}, 32'd0);
      step();
      rstn = 1'b1;
      check_output("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
      check_output("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
      check_output("rst_ex_rd", {27'd0, ex_rd}, 32'd0);
      check_output("rst_ex_ctrl", {16'd0, ex_ctrl}, 32'd0);
      #1;
      check_output("rst_x9_free", {31'd0, id_ready}, 32'd1);
      step();
      check_output("rst_reader_rs1", ex_rs1_data, 32'h99990009);
      idle();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data width.
REQ-002 SHALL have parameter CTRLW, default 16, meaning width of opaque decode control bundle passed to execute.
REQ-003 SHALL have ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- id_valid  in  1  decode offers instruction.
- id_ready  out  1  stage accepts instruction.
- id_rs1, id_rs2, id_rd  in  5 each  register addresses.
- id_use_rs1, id_use_rs2, id_wr_rd  in  1 each  operand-use and rd-write flags.
- id_ctrl  in  CTRLW  control bundle.
- rf_rs1_raddr, rf_rs2_raddr  out  5 each  register file read addresses.
- rf_rs1_rdata, rf_rs2_rdata  in  XLEN each  register file read data, combinational.
- wb_valid  in  1  writeback occurring this cycle.
- wb_rd  in  5  writeback address.
- wb_data  in  XLEN  writeback data.
- flush  in  1  discard un-accepted output entry.
- ex_valid  out  1  operands valid to execute.
- ex_ready  in  1  execute accepts.
- ex_rs1_data, ex_rs2_data  out  XLEN each  operands.
- ex_rd  out  5  destination address.
- ex_wr_rd  out  1  destination write flag.
- ex_ctrl  out  CTRLW  registered id_ctrl.
- stall_cnt  out  16  saturating count of hazard-stall cycles.

Function
REQ-004 rf_rs1_raddr/rf_rs2_raddr SHALL equal id_rs1/id_rs2 combinationally.
REQ-005 Scoreboard: 32 busy bits; busy[0] SHALL always read 0.
REQ-006 Operand hazard: use flag set, busy[rs] set, and not (wb_valid and wb_rd==rs).
REQ-007 WAW hazard: id_wr_rd, id_rd!=0, and busy[id_rd] set with no same-cycle clear.
REQ-008 id_ready = !flush and no hazard and (!ex_valid or ex_ready).
REQ-009 Issue occurs on id_valid and id_ready; output register SHALL load on the next edge (latency 1 cycle). The output register SHALL then be FULL (ex_valid=1).
REQ-010 Operand select priority:
- address 0 -> 0;
- wb_valid and wb_rd==rs -> wb_data (bypass);
- else rf rdata.
- Unused operands SHALL load 0.
REQ-011 On issue with id_wr_rd and id_rd!=0, busy[id_rd] SHALL set.
REQ-012 wb_valid with wb_rd!=0 SHALL clear busy[wb_rd]; a set and a clear of the same index in one cycle SHALL resolve to set.
REQ-013 Output states:
- EMPTY->FULL on issue.
- FULL->EMPTY on ex_ready without issue.
- FULL->FULL on ex_ready with issue.
- FULL holds all ex_* stable while !ex_ready.
REQ-014 Flush SHALL force EMPTY on the next edge.
- If FULL, not accepted that cycle, with ex_wr_rd and ex_rd!=0: busy[ex_rd] SHALL clear.
- Flush SHALL block issue that cycle.
REQ-015 stall_cnt SHALL increment when id_valid and a hazard stalls, and SHALL saturate at 16'hFFFF.

Reset
REQ-016 When rstn=0 at an edge, the following SHALL load their stated values, overriding flush and wb:
- ex_valid 0;
- all busy bits 0;
- ex_rs1_data, ex_rs2_data, ex_rd, ex_wr_rd, ex_ctrl 0;
- stall_cnt 0.
REQ-017 id_ready SHALL be 0 while rstn=0.

Structure
REQ-018 Package rv32i_pkg SHALL hold the following:
- XLEN default;
- REG_ADDR_W=5;
- NUM_REGS=32;
- the operand-select enum {SEL_ZERO, SEL_BYPASS, SEL_RF}.
REQ-019 The busy array with set/clear/query logic SHALL be sub-module scoreboard.

Verification
REQ-020 Back-to-back RAW:
- Issue rd=x5, then an instruction reading rs1=x5.
- Expected: id_ready=0 until wb_valid with wb_rd=5 and wb_data=0xDEADBEEF; issue occurs that cycle; ex_rs1_data=0xDEADBEEF.
REQ-021 Writes to x0:
- Issue rd=0, then read rs1=0 while wb_valid with wb_rd=0 and wb_data=0x1234.
- Expected: no stall; ex_rs1_data=0.
REQ-022 Backpressure:
- ex_ready=0 for 3 cycles with FULL.
- Expected: ex_* unchanged, id_ready=0; on ex_ready=1, next instruction loads the next cycle.
REQ-023 Flush:
- Flush while FULL holding rd=x7 un-accepted.
- Expected: next cycle ex_valid=0 and busy[7]=0; a reader of x7 issues immediately.
REQ-024 WAW and counter:
- Issue rd=x3 twice.
- Expected: the second stalls; stall_cnt increments once per stalled cycle; preset near 16'hFFFF it holds at 16'hFFFF.
REQ-025 Reset mid-operation:
- rstn=0 with FULL and busy[9]=1.
- Expected: next cycle ex_valid=0, busy[9]=0, stall_cnt=0.
